// File: rtl/mvau_weight_ctrl.sv
// Weight-memory address sequencer for one MVAU bank: walks SIMD folds inside neuron folds,
// paced by activation beats, and freezes the memory output under downstream backpressure.
module mvau_weight_ctrl #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned PE           = 2,
    parameter int unsigned MatrixW      = 8,
    parameter int unsigned MatrixH      = 4,
    parameter int unsigned WMEM_DEPTH   = (MatrixW / SIMD) * (MatrixH / PE),
    parameter int unsigned WMEM_ADDR_BW = 3,
    parameter int unsigned REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [REP_BW-1:0]       cfg_reps,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic                    out_sf_last,
    output logic                    out_nf_last,
    output logic                    out_last,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr
);

    localparam int unsigned SF    = MatrixW / SIMD;
    localparam int unsigned NF    = MatrixH / PE;
    localparam int unsigned SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int unsigned NF_BW = (NF > 1) ? $clog2(NF) : 1;

    localparam logic [SF_BW-1:0]        SF_MAX  = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_MAX  = NF_BW'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] PTR_MAX = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [WMEM_ADDR_BW-1:0] r_ptr;
    logic [WMEM_ADDR_BW-1:0] r_hold_addr;
    logic [SF_BW-1:0]        r_sf_cnt;
    logic [NF_BW-1:0]        r_nf_cnt;
    logic [REP_BW-1:0]       r_vec_cnt;
    logic [REP_BW-1:0]       r_reps;
    logic                    r_out_v;
    logic                    r_sf_last;
    logic                    r_nf_last;
    logic                    r_last;
    logic                    r_done;

    logic                    w_stall;
    logic                    w_in_rdy;
    logic                    w_fire;
    logic                    w_sf_end;
    logic                    w_nf_end;
    logic                    w_vec_end;
    logic                    w_accept_start;
    logic                    w_drain_exit;
    logic [REP_BW-1:0]       w_reps_in;

    assign w_stall   = r_out_v && !out_rdy;
    assign w_in_rdy  = (r_state == ST_RUN) && !w_stall;
    assign w_fire    = in_v && w_in_rdy;

    assign w_sf_end  = (r_sf_cnt == SF_MAX);
    assign w_nf_end  = w_sf_end && (r_nf_cnt == NF_MAX);
    assign w_vec_end = w_nf_end && (r_vec_cnt == (r_reps - REP_BW'(1)));

    assign w_accept_start = (r_state == ST_IDLE) && start;
    // A zero repetition count still runs one full vector.
    assign w_reps_in      = (cfg_reps == '0) ? REP_BW'(1) : cfg_reps;

    assign w_drain_exit = (r_state == ST_DRAIN) && (!r_out_v || (out_rdy && r_last));

    // Re-presenting the held address keeps the synchronous-read output frozen during a stall.
    assign wmem_addr = w_fire ? r_ptr : r_hold_addr;

    assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done        = r_done;
    assign in_rdy      = w_in_rdy;
    assign out_v       = r_out_v;
    assign out_sf_last = r_sf_last;
    assign out_nf_last = r_nf_last;
    assign out_last    = r_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_fire && w_vec_end) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_exit) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_hold_addr <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_addr <= wmem_addr;
            r_done      <= w_drain_exit;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr     <= '0;
            r_sf_cnt  <= '0;
            r_nf_cnt  <= '0;
            r_vec_cnt <= '0;
            r_reps    <= REP_BW'(1);
        end else if (w_accept_start) begin
            r_ptr     <= '0;
            r_sf_cnt  <= '0;
            r_nf_cnt  <= '0;
            r_vec_cnt <= '0;
            r_reps    <= w_reps_in;
        end else if (w_fire) begin
            r_ptr    <= (r_ptr == PTR_MAX) ? '0 : r_ptr + WMEM_ADDR_BW'(1);
            r_sf_cnt <= w_sf_end ? '0 : r_sf_cnt + SF_BW'(1);
            if (w_sf_end) begin
                r_nf_cnt <= w_nf_end ? '0 : r_nf_cnt + NF_BW'(1);
            end
            if (w_nf_end) begin
                r_vec_cnt <= r_vec_cnt + REP_BW'(1);
            end
        end
    end

    // Beat valid and fold flags travel with the memory read, one cycle behind the fire.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_v   <= 1'b0;
            r_sf_last <= 1'b0;
            r_nf_last <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_fire) begin
            r_out_v   <= 1'b1;
            r_sf_last <= w_sf_end;
            r_nf_last <= w_nf_end;
            r_last    <= w_vec_end;
        end else if (!w_stall) begin
            r_out_v   <= 1'b0;
            r_sf_last <= 1'b0;
            r_nf_last <= 1'b0;
            r_last    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvau_weight_ctrl.sv
// Directed bench for mvau_weight_ctrl with a registered-read weight memory model and a
// negedge monitor that follows the issue and delivery order of weight beats.
module tb_mvau_weight_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_reps = '0;
    logic        busy;
    logic        done;
    logic        in_v = 1'b0;
    logic        in_rdy;
    logic        out_v;
    logic        out_rdy = 1'b0;
    logic        out_sf_last;
    logic        out_nf_last;
    logic        out_last;
    logic [2:0]  wmem_addr;

    logic [7:0]  mem [8];
    logic [7:0]  mem_out;

    int n_checks = 0;
    int n_fail   = 0;
    int issue_idx = 0;
    int recv_idx  = 0;
    int total     = 0;
    bit mon_en    = 1'b0;
    logic       prev_fire  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_addr  = '0;

    mvau_weight_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .cfg_reps    (cfg_reps),
        .busy        (busy),
        .done        (done),
        .in_v        (in_v),
        .in_rdy      (in_rdy),
        .out_v       (out_v),
        .out_rdy     (out_rdy),
        .out_sf_last (out_sf_last),
        .out_nf_last (out_nf_last),
        .out_last    (out_last),
        .wmem_addr   (wmem_addr)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) mem_out <= mem[wmem_addr];

    function automatic logic [7:0] word_of(input int a);
        return 8'(32'h30 + a * 7);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Beat k of a run reads word k%8; fold flags follow from SF=4, NF=2.
    always @(negedge aclk) begin
        if (mon_en) begin
            check_eq("out_v_timing", out_v, prev_fire || prev_stall);
            if (out_v && !out_rdy) check_eq("stall_in_rdy", in_rdy, 0);
            if (in_v && in_rdy) begin
                check_eq("issue_addr", wmem_addr, issue_idx % 8);
                issue_idx++;
            end else begin
                check_eq("hold_addr", wmem_addr, prev_addr);
            end
            if (!out_v) begin
                check_eq("idle_flags", {out_sf_last, out_nf_last, out_last}, 0);
            end else if (out_rdy) begin
                check_eq("beat_data", mem_out, word_of(recv_idx % 8));
                check_eq("sf_last", out_sf_last, (recv_idx % 4) == 3);
                check_eq("nf_last", out_nf_last, (recv_idx % 8) == 7);
                check_eq("last", out_last, recv_idx == total - 1);
                recv_idx++;
            end
        end
        prev_fire  = in_v && in_rdy;
        prev_stall = out_v && !out_rdy;
        prev_addr  = wmem_addr;
    end

    task automatic start_run(input logic [15:0] reps, input int exp_total);
        @(posedge aclk); #1;
        start = 1'b1;
        cfg_reps = reps;
        in_v = 1'b0;
        out_rdy = 1'b1;
        total = exp_total;
        issue_idx = 0;
        recv_idx = 0;
        mon_en = 1'b1;
        @(negedge aclk);
        check_eq("pre_start_in_rdy", in_rdy, 0);
        check_eq("pre_start_busy", busy, 0);
        @(posedge aclk); #1;
        start = 1'b0;
        cfg_reps = 16'hffff;
        @(negedge aclk);
        check_eq("first_in_rdy", in_rdy, 1);
        check_eq("run_busy", busy, 1);
    endtask

    task automatic drive_run(input logic [15:0] pat, input int mid_start, input int stall_word,
                             input int stall_len);
        int  cyc = 0;
        int  stall_left = 0;
        bit  armed = (stall_len > 0);
        bit  fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(posedge aclk); #1;
            in_v    = pat[cyc % 16];
            start   = (cyc == mid_start);
            if (cyc == mid_start) cfg_reps = 16'd7;
            out_rdy = (stall_left == 0);
            @(negedge aclk);
            if (stall_left > 0) begin
                check_eq("stall_addr", wmem_addr, stall_word);
                check_eq("stall_in_rdy_hold", in_rdy, 0);
                check_eq("stall_out_v", out_v, 1);
                check_eq("stall_data", mem_out, word_of(stall_word));
                check_eq("stall_sf_last", out_sf_last, (stall_word % 4) == 3);
                stall_left--;
            end else if (armed && in_v && in_rdy && wmem_addr == stall_word[2:0]) begin
                armed = 1'b0;
                stall_left = stall_len;
            end
            if (done) begin
                fin = 1'b1;
                check_eq("done_busy_low", busy, 0);
            end
            cyc++;
        end
        start = 1'b0;
        check_eq("done_seen", fin, 1);
        @(posedge aclk); #1;
        @(negedge aclk);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_after_run", busy, 0);
        check_eq("issued_count", issue_idx, total);
        check_eq("received_count", recv_idx, total);
        mon_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = word_of(i);

        // Reset and idle: nothing moves without a start, even with traffic present.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_addr", wmem_addr, 0);
        check_eq("rst_out_v", out_v, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        in_v = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            check_eq("idle_addr", wmem_addr, 0);
            check_eq("idle_in_rdy", in_rdy, 0);
            check_eq("idle_out_v", out_v, 0);
            check_eq("idle_busy", busy, 0);
        end

        // cfg_reps=0 behaves as a single vector.
        start_run(16'd0, 8);
        drive_run(16'hffff, -1, 0, 0);

        // Single vector at full throughput.
        start_run(16'd1, 8);
        drive_run(16'hffff, -1, 0, 0);

        // Three vectors, address wraps twice.
        start_run(16'd3, 24);
        drive_run(16'hffff, -1, 0, 0);

        // Backpressure for 4 cycles while word 5 is presented.
        start_run(16'd1, 8);
        drive_run(16'hffff, -1, 5, 4);

        // Activation bubbles plus a start pulse that must be ignored mid-run.
        start_run(16'd2, 16);
        drive_run(16'hb2e5, 6, 0, 0);

        // Reset once five beats of a two-vector run have been issued.
        start_run(16'd2, 16);
        for (int i = 0; i < 50 && issue_idx < 5; i++) begin
            @(posedge aclk); #1;
            in_v = 1'b1;
            @(negedge aclk);
        end
        check_eq("mid_issue_count", issue_idx, 5);
        mon_en = 1'b0;
        #1;
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_out_v", out_v, 0);
        check_eq("mid_rst_addr", wmem_addr, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_in_rdy", in_rdy, 0);
        check_eq("mid_rst_last", out_last, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_eq("no_done_after_rst", done, 0);
            check_eq("idle_after_rst", busy, 0);
        end
        start_run(16'd1, 8);
        drive_run(16'hffff, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
